// File: rtl/seq_detect_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_param_if
//  Purpose  : Bundles the bit-pulse inputs, pattern-load controls and match
//             status outputs of the parameterised sequence detector.
//  Ports    : P1/P2     - '1' / '0' bit pulses (exactly one high = a bit)
//             mode      - 0 overlapping, 1 non-overlapping detection
//             load      - strobe loading pat_in as the new pattern
//             pat_in    - new pattern, MSB is the first bit of the sequence
//             z         - Mealy match flag
//             match_cnt - saturating count of matches
//             fill      - number of valid history bits
//  Modports : master drives the controls, slave is the detector.
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_detect_param_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    localparam int FILL_W = $clog2(WIDTH + 1);

    logic               P1;
    logic               P2;
    logic               mode;
    logic               load;
    logic [WIDTH-1:0]   pat_in;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic [FILL_W-1:0]  fill;

    modport master (
        output P1, P2, mode, load, pat_in,
        input  z, match_cnt, fill
    );

    modport slave (
        input  P1, P2, mode, load, pat_in,
        output z, match_cnt, fill
    );
endinterface
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_param
//  Purpose  : Parameterised serial pattern detector with run-time pattern
//             load, overlapping / non-overlapping modes and a saturating
//             match counter.
//  Ports    : clk   - single clock, rising edge
//             reset - asynchronous, active-low reset
//             bus   - seq_detect_param_if slave (bit pulses, mode, pattern
//                     load, z, match_cnt, fill)
//  Params   : WIDTH (2..16) pattern length, PATTERN reset pattern,
//             CNT_W match counter width
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(4'b1011),
    parameter int               CNT_W   = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    seq_detect_param_if.slave bus
);
    localparam int                FILL_W     = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] C_FILL_MAX = FILL_W'(WIDTH - 1);

    // FILLING: fewer than WIDTH-1 history bits; ARMED: the next accepted
    // bit can complete a match.
    typedef enum logic [0:0] {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_pat;
    logic [WIDTH-2:0]   r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [FILL_W-1:0]  w_fill_nxt;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_bit_vld;
    logic               w_bit;
    logic               w_match;
    logic [WIDTH-1:0]   w_shift;

    // Exactly one pulse high means a bit; both or neither are ignored.
    assign w_bit_vld = bus.P1 ^ bus.P2;
    assign w_bit     = bus.P1;
    assign w_shift   = {r_hist, w_bit};

    // ------------------------------------------------------------------
    // Next-state / match logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_match     = 1'b0;

        if (bus.load) begin
            // Load wins over any offered bit and restarts the history.
            w_state_nxt = FILLING;
            w_fill_nxt  = '0;
        end else if (w_bit_vld) begin
            w_match = (r_state == ARMED) && (w_shift == r_pat);
            if (w_match && bus.mode) begin
                // Non-overlap: none of the matched bits may be reused.
                w_state_nxt = FILLING;
                w_fill_nxt  = '0;
            end else if (r_state == ARMED) begin
                w_state_nxt = ARMED;
                w_fill_nxt  = C_FILL_MAX;
            end else begin
                w_fill_nxt  = r_fill + FILL_W'(1);
                w_state_nxt = (w_fill_nxt == C_FILL_MAX) ? ARMED : FILLING;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, history, pattern and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FILLING;
            r_fill  <= '0;
            r_hist  <= '0;
            r_pat   <= PATTERN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            if (bus.load) begin
                r_pat <= bus.pat_in;
            end else if (w_bit_vld) begin
                r_hist <= w_shift[WIDTH-2:0];
            end
            if (w_match && !(&r_cnt)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.z         = w_match;
    assign bus.match_cnt = r_cnt;
    assign bus.fill      = r_fill;
endmodule
`default_nettype wire

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 4'b1011 (WIDTH bits): pattern loaded at reset; MSB is the first bit of the sequence.
REQ-003 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port P1, input, 1: pulse representing a '1' bit.
REQ-007 SHALL have port P2, input, 1: pulse representing a '0' bit.
REQ-008 SHALL have port mode, input, 1: 0 = overlapping detection, 1 = non-overlapping detection.
REQ-009 SHALL have port load, input, 1: strobe that loads a new pattern from pat_in.
REQ-010 SHALL have port pat_in, input, WIDTH: new pattern; MSB is the first bit.
REQ-011 SHALL have port z, output, 1: Mealy match flag.
REQ-012 SHALL have port match_cnt, output, CNT_W: saturating count of matches.
REQ-013 SHALL have port fill, output, clog2(WIDTH+1): number of valid history bits.

Function
REQ-014 SHALL accept a bit in a cycle only when P1 XOR P2 is 1; the bit value SHALL be P1.
REQ-015 SHALL ignore P1=P2=1 and P1=P2=0; history, fill, z and counter SHALL be unchanged in those cycles.
REQ-016 SHALL keep internal registers pat_reg[WIDTH-1:0] and hist[WIDTH-2:0]; an accepted bit SHALL shift into the hist LSB.
REQ-017 SHALL increment fill on each accepted bit, saturating at WIDTH-1.
REQ-018 SHALL drive z combinationally high in the same cycle as the completing bit when all of these hold: bit accepted, load=0, fill=WIDTH-1, and {hist,bit}=pat_reg.
REQ-019 SHALL, in overlap mode (mode=0), update hist and fill normally after a match, so a trailing pattern prefix can begin the next match.
REQ-020 SHALL, in non-overlap mode (mode=1), clear fill to 0 on the edge following a match, so no bit of a matched sequence is reused.
REQ-021 SHALL sample mode every cycle; a change in mode SHALL affect only the matches that follow it.
REQ-022 SHALL, when load=1, set pat_reg to pat_in and fill to 0, discard any bit offered that cycle, and hold z at 0.
REQ-023 SHALL increment match_cnt on each edge where z=1, saturating at all-ones with no wrap.
REQ-024 SHALL make load take priority over bit acceptance when both occur in the same cycle.
REQ-025 SHALL be realised as a control FSM with states FILLING (fill<WIDTH-1) and ARMED (fill=WIDTH-1): a non-overlap match or a load returns to FILLING; reset enters FILLING.

Reset
REQ-026 SHALL, while reset=0 and regardless of clk, force fill=0, hist=0, pat_reg=PATTERN and match_cnt=0, with z=0.
REQ-027 SHALL accept no bits during reset and SHALL resume acceptance on the first rising clk edge after reset deasserts.
REQ-028 SHALL, on reset asserted mid-sequence, discard the partial history; no match SHALL be completed from bits accepted before reset.

Verification (WIDTH=4, PATTERN=1011, CNT_W=8 unless stated)
REQ-029 SHALL cover overlap: mode=0, bits 1,0,1,1,0,1,1 -> z=1 on bits 4 and 7 only; match_cnt=2.
REQ-030 SHALL cover non-overlap: mode=1, same stream -> z=1 on bit 4 only; match_cnt=1; fill=3 at end.
REQ-031 SHALL cover ignored inputs: bits 1,0, then P1=P2=1 for 1 cycle, then idle for 2 cycles, then 1,1 -> z=1 on the final bit; fill unchanged during the ignored cycles.
REQ-032 SHALL cover pattern load: stream 1,0,1, then load=1 with pat_in=1100 while P1=1 -> no z, fill=0; then 1,1,0,0 -> z=1 on the last 0.
REQ-033 SHALL cover counter saturation: CNT_W=2, mode=0, stream 1011011011011 (4 matches) -> match_cnt=3 after the 3rd and 4th matches.
REQ-034 SHALL cover reset mid-operation: bits 1,0,1, then reset=0 for half a cycle, then bit 1 -> z=0, match_cnt=0, fill=1.
